clk_div_bank: RTL

//  NCH-channel programmable integer clock divider. Each channel divides the system clock by a

---
 rtl/clk_div_pkg.sv | 19 +
 rtl/clk_div_chan.sv | 79 +++++++
 rtl/clk_div_bank.sv | 62 ++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
//------------------------------------------------------------------------------
// clk_div_pkg : shared defaults and half-period helper for the divider bank
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package clk_div_pkg;

  localparam int unsigned c_def_w   = 26;
  localparam int unsigned c_def_div = 33868800;

  // High phase length: ceil(div/2), so odd divisors spend the extra cycle high.
  function automatic logic [31:0] hi_of(input logic [31:0] div);
    return div - (div >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_chan.sv
//------------------------------------------------------------------------------
// clk_div_chan : one divider channel with shadowed divisor and period tick
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned W       = c_def_w,
  parameter int unsigned DEF_DIV = c_def_div
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         wr_i,
  input  logic [W-1:0] wdiv_i,
  input  logic         sync_i,
  output logic         pend_o,
  output logic         clk_out_o,
  output logic         tick_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic [W-1:0] shadow_q, shadow_d;
  logic         pend_q, pend_d;
  logic         clk_out_q, clk_out_d;
  logic         tick_q, tick_d;
  logic [W-1:0] hi;
  logic         wrap;
  logic         stop;

  always_comb begin
    hi        = W'(hi_of(32'(div_q)));
    wrap      = (cnt_q == div_q - W'(1));
    stop      = sync_i || !en_i;
    cnt_d     = (stop || wrap) ? '0 : cnt_q + W'(1);
    clk_out_d = !stop && (cnt_q < hi);
    tick_d    = !stop && (cnt_q == '0);
    div_d     = div_q;
    shadow_d  = shadow_q;
    pend_d    = pend_q;
    // Apply reads the old shadow first, so a same-cycle write stays pending.
    if (pend_q && (stop || wrap)) begin
      div_d  = shadow_q;
      pend_d = 1'b0;
    end
    if (wr_i) begin
      shadow_d = wdiv_i;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      div_q     <= W'(DEF_DIV);
      shadow_q  <= W'(DEF_DIV);
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign pend_o    = pend_q;
  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;

endmodule

`default_nettype wire

// File: rtl/clk_div_bank.sv
//------------------------------------------------------------------------------
// clk_div_bank : NCH-channel run-time programmable integer clock divider bank
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned W       = c_def_w,
  parameter int unsigned DEF_DIV = c_def_div,
  localparam int unsigned CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic           cfg_wr,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [W-1:0]   cfg_div,
  input  logic           sync_all,
  output logic           cfg_err,
  output logic [NCH-1:0] pend,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
);

  logic cfg_ok;
  logic cfg_err_q;

  assign cfg_ok = (cfg_div != '0) && (32'(cfg_ch) < NCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_wr && !cfg_ok;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clk_div_chan #(
      .W       (W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en_i      (en[i]),
      .wr_i      (cfg_wr && cfg_ok && (32'(cfg_ch) == i)),
      .wdiv_i    (cfg_div),
      .sync_i    (sync_all),
      .pend_o    (pend[i]),
      .clk_out_o (clk_out[i]),
      .tick_o    (tick[i])
    );
  end

endmodule

`default_nettype wire
